hazard_forward_unit: RTL

Parametrised hazard-resolution block for the in-order pipeline, sitting between the decode stage and the ID/EX register. It generalises operand forwarding to NUM_SRC source operands and detects load-use hazards. It tracks writes in flight from long-latency units (mul/div) in a register scoreboard and raises stall/bubble controls. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_forward_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//
// Hazard-resolution block between decode and the ID/EX register.
//  - Operand forwarding for NUM_SRC execute-stage sources (EX/MEM beats MEM/WB).
//  - Load-use hazard detection against the instruction in EX.
//  - Register scoreboard (one busy bit per register) for writes still in
//    flight in long-latency units; RAW and WAW hazards stall decode.
//  - Saturating counter of stall cycles.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   IF_ID_Rs/RsValid/Rd/RdValid     decode-stage operands and destination
//   ID_EX_Rs/Rd/MemRead             execute-stage operands, destination, load flag
//   EX_MEM_Rd/RegWrite              EX/MEM destination and write enable
//   MEM_WB_Rd/RegWrite              MEM/WB destination and write enable
//   LongOp_Issue/Rd                 decode instruction dispatched to mul/div
//   LongOp_Done/DoneRd              mul/div result written back this cycle
//   StallCountClr                   synchronous clear of StallCount
//   ForwardSel                      2 bits per operand: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   Stall, Bubble                   hold PC and IF/ID; insert NOP into ID/EX
//   LongPending                     at least one long op in flight
//   StallCount                      saturating count of stall cycles
module hazard_forward_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] IF_ID_Rs,
  input  logic [NUM_SRC-1:0]                IF_ID_RsValid,
  input  logic [REG_ADDR_WIDTH-1:0]         IF_ID_Rd,
  input  logic                              IF_ID_RdValid,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] ID_EX_Rs,
  input  logic [REG_ADDR_WIDTH-1:0]         ID_EX_Rd,
  input  logic                              ID_EX_MemRead,
  input  logic [REG_ADDR_WIDTH-1:0]         EX_MEM_Rd,
  input  logic                              EX_MEM_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0]         MEM_WB_Rd,
  input  logic                              MEM_WB_RegWrite,
  input  logic                              LongOp_Issue,
  input  logic [REG_ADDR_WIDTH-1:0]         LongOp_Rd,
  input  logic                              LongOp_Done,
  input  logic [REG_ADDR_WIDTH-1:0]         LongOp_DoneRd,
  input  logic                              StallCountClr,
  output logic [2*NUM_SRC-1:0]              ForwardSel,
  output logic                              Stall,
  output logic                              Bubble,
  output logic                              LongPending,
  output logic [CNT_WIDTH-1:0]              StallCount
);

  localparam int NREG = 2 ** REG_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            load_use;
  logic            sb_raw;
  logic            sb_waw;
  logic            issue_ok;

  // Forwarding: EX/MEM holds the younger result, so it is tested first.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    ForwardSel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (EX_MEM_RegWrite && (EX_MEM_Rd != '0) &&
          (EX_MEM_Rd == ID_EX_Rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
        ForwardSel[2*k +: 2] = 2'b10;
      end else if (MEM_WB_RegWrite && (MEM_WB_Rd != '0) &&
                   (MEM_WB_Rd == ID_EX_Rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
        ForwardSel[2*k +: 2] = 2'b01;
      end
    end
  end

  // Hazards look only at the registered busy vector: a Done releases the
  // stall one cycle later, there is no same-cycle bypass.
  always_comb begin
    load_use = 1'b0;
    sb_raw   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (IF_ID_RsValid[k]) begin
        if (ID_EX_MemRead && (ID_EX_Rd != '0) &&
            (ID_EX_Rd == IF_ID_Rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
          load_use = 1'b1;
        end
        if (busy[IF_ID_Rs[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]]) begin
          sb_raw = 1'b1;
        end
      end
    end
    sb_waw = IF_ID_RdValid && busy[IF_ID_Rd];
  end

  assign Stall       = ~rst & (load_use | sb_raw | sb_waw);
  assign Bubble      = Stall;
  assign LongPending = |busy;

  // A stalled decode instruction is not really dispatched, so its issue is dropped.
  assign issue_ok = LongOp_Issue && !Stall && (LongOp_Rd != '0);

  // Clear first, then set, so a same-register Issue+Done leaves the bit set.
  always_comb begin
    busy_next = busy;
    if (LongOp_Done) begin
      busy_next[LongOp_DoneRd] = 1'b0;
    end
    if (issue_ok) begin
      busy_next[LongOp_Rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it is fully reset;
  // this is what discards long ops pending across a reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else if (StallCountClr) begin
      StallCount <= '0;
    end else if (Stall && (StallCount != CNT_MAX)) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule
